// File: rtl/bram_stream_reader_pkg.sv
// Shared types and sizing helpers for the block-RAM stream reader.
// The output FIFO depth is derived from the RAM read latency.
package bram_stream_reader_pkg;

    typedef enum logic [1:0] {
        StIdle  = 2'd0,
        StRun   = 2'd1,
        StDrain = 2'd2
    } state_e;

    // Two spare entries on top of the in-flight reads keep the stream bubble-free.
    function automatic int unsigned fifo_depth(input int unsigned rd_lat);
        return rd_lat + 2;
    endfunction

    function automatic int unsigned cnt_width(input int unsigned depth);
        return $clog2(depth + 1);
    endfunction

endpackage

// File: rtl/bram_stream_reader_stream_fifo.sv
// Small synchronous FIFO for the reader's output stream.
// Simultaneous push and pop leave the occupancy unchanged.
module bram_stream_reader_stream_fifo #(
    parameter int unsigned DEPTH = 3,
    parameter int unsigned WIDTH = 16,
    parameter int unsigned CNT_W = $clog2(DEPTH + 1)
) (
    input  logic             i_clk,
    input  logic             i_rst_n,
    input  logic             i_push,
    input  logic             i_pop,
    input  logic [WIDTH-1:0] i_din,
    output logic [WIDTH-1:0] o_dout,
    output logic [CNT_W-1:0] o_count,
    output logic             o_empty
);
    localparam int unsigned PTR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam logic [PTR_W-1:0] LAST = PTR_W'(DEPTH - 1);

    logic [WIDTH-1:0] r_mem [DEPTH];
    logic [PTR_W-1:0] r_rd_ptr;
    logic [PTR_W-1:0] r_wr_ptr;
    logic [CNT_W-1:0] r_count;
    logic             w_do_push;
    logic             w_do_pop;

    assign w_do_pop  = i_pop && (r_count != '0);
    assign w_do_push = i_push && ((r_count != CNT_W'(DEPTH)) || w_do_pop);

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            r_mem    <= '{default: '0};
            r_rd_ptr <= '0;
            r_wr_ptr <= '0;
            r_count  <= '0;
        end else begin
            if (w_do_push) begin
                r_mem[r_wr_ptr] <= i_din;
                r_wr_ptr        <= (r_wr_ptr == LAST) ? '0 : r_wr_ptr + PTR_W'(1);
            end
            if (w_do_pop) begin
                r_rd_ptr <= (r_rd_ptr == LAST) ? '0 : r_rd_ptr + PTR_W'(1);
            end
            case ({w_do_push, w_do_pop})
                2'b10:   r_count <= r_count + CNT_W'(1);
                2'b01:   r_count <= r_count - CNT_W'(1);
                default: r_count <= r_count;
            endcase
        end
    end

    assign o_dout  = r_mem[r_rd_ptr];
    assign o_count = r_count;
    assign o_empty = (r_count == '0);

endmodule

// File: rtl/bram_stream_reader.sv
// Reads a run of consecutive words from a simple-dual-port RAM (port B) and
// presents them as a valid/ready stream, throttling reads under backpressure.
module bram_stream_reader
    import bram_stream_reader_pkg::*;
#(
    parameter int unsigned ADDR_W = 4,
    parameter int unsigned DATA_W = 16,
    parameter int unsigned RD_LAT = 1
) (
    input  logic              i_clk,
    input  logic              i_rst_n,
    input  logic              i_start,
    input  logic [ADDR_W-1:0] i_base_addr,
    input  logic [ADDR_W:0]   i_len,
    output logic              o_busy,
    output logic              o_done,
    output logic [ADDR_W-1:0] o_addrb,
    input  logic [DATA_W-1:0] i_doutb,
    output logic              o_m_valid,
    input  logic              i_m_ready,
    output logic [DATA_W-1:0] o_m_data
);
    localparam int unsigned FIFO_DEPTH = fifo_depth(RD_LAT);
    localparam int unsigned CNT_W      = cnt_width(FIFO_DEPTH);
    localparam int unsigned CRED_W     = CNT_W + 1;

    state_e              r_state;
    logic [ADDR_W-1:0]   r_addr;
    logic [ADDR_W:0]     r_len;
    logic [ADDR_W:0]     r_issued;
    logic [RD_LAT-1:0]   r_vpipe;
    logic                r_busy;
    logic                r_done;

    logic [RD_LAT-1:0]   w_vpipe_next;
    logic [CRED_W-1:0]   w_in_flight;
    logic [CNT_W-1:0]    w_fifo_count;
    logic                w_fifo_empty;
    logic                w_credit_ok;
    logic                w_issue;
    logic                w_push;
    logic                w_pop;
    logic                w_last_pop;

    // Every outstanding read or buffered word holds one FIFO slot, so the FIFO cannot overflow.
    assign w_in_flight  = CRED_W'($countones(r_vpipe));
    assign w_credit_ok  = (w_in_flight + CRED_W'(w_fifo_count)) < CRED_W'(FIFO_DEPTH);
    assign w_issue      = (r_state == StRun) && (r_issued < r_len) && w_credit_ok;
    assign w_vpipe_next = RD_LAT'({r_vpipe, w_issue});
    assign w_push       = r_vpipe[RD_LAT-1];
    assign w_pop        = !w_fifo_empty && i_m_ready;
    assign w_last_pop   = (r_state == StDrain) && w_pop && (w_fifo_count == CNT_W'(1))
                          && (w_in_flight == '0);

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            r_state  <= StIdle;
            r_addr   <= '0;
            r_len    <= '0;
            r_issued <= '0;
            r_vpipe  <= '0;
            r_busy   <= 1'b0;
            r_done   <= 1'b0;
        end else begin
            r_done  <= 1'b0;
            r_vpipe <= w_vpipe_next;
            if (w_issue) begin
                r_addr   <= r_addr + ADDR_W'(1);
                r_issued <= r_issued + (ADDR_W + 1)'(1);
            end
            case (r_state)
                StIdle: begin
                    if (i_start) begin
                        if (i_len != '0) begin
                            r_addr   <= i_base_addr;
                            r_len    <= i_len;
                            r_issued <= '0;
                            r_busy   <= 1'b1;
                            r_state  <= StRun;
                        end else begin
                            r_done <= 1'b1;
                        end
                    end
                end
                StRun: begin
                    if (r_issued == r_len) begin
                        r_state <= StDrain;
                    end
                end
                StDrain: begin
                    if (w_last_pop) begin
                        r_busy  <= 1'b0;
                        r_done  <= 1'b1;
                        r_state <= StIdle;
                    end
                end
                default: r_state <= StIdle;
            endcase
        end
    end

    bram_stream_reader_stream_fifo #(
        .DEPTH (FIFO_DEPTH),
        .WIDTH (DATA_W),
        .CNT_W (CNT_W)
    ) u_fifo (
        .i_clk   (i_clk),
        .i_rst_n (i_rst_n),
        .i_push  (w_push),
        .i_pop   (w_pop),
        .i_din   (i_doutb),
        .o_dout  (o_m_data),
        .o_count (w_fifo_count),
        .o_empty (w_fifo_empty)
    );

    assign o_m_valid = !w_fifo_empty;
    assign o_addrb   = r_addr;
    assign o_busy    = r_busy;
    assign o_done    = r_done;

endmodule

// File: tb/tb_bram_stream_reader.sv
// Directed bench for bram_stream_reader with a behavioural 1-cycle-latency
// simple-dual-port RAM model.
module tb_bram_stream_reader;
    logic        clk = 1'b0;
    logic        rst_n;
    logic        start;
    logic [3:0]  base_addr;
    logic [4:0]  len;
    logic        busy;
    logic        done;
    logic [3:0]  addrb;
    logic [15:0] doutb;
    logic        m_valid;
    logic        m_ready;
    logic [15:0] m_data;

    logic        wea;
    logic [3:0]  addra;
    logic [15:0] dina;
    logic [15:0] mem [16];

    int          n_cmp = 0;
    int          n_err = 0;
    int          done_cnt = 0;
    int          n;
    logic [15:0] got [$];
    logic [3:0]  addr_seq [$];
    logic [3:0]  lead;

    always #5 clk = ~clk;

    always @(posedge clk) begin
        if (wea) mem[addra] <= dina;
        doutb <= mem[addrb];
    end

    always @(posedge clk) begin
        if (rst_n) begin
            if (m_valid && m_ready) got.push_back(m_data);
            if (done) done_cnt++;
            if (busy && (addr_seq.size() == 0 || addr_seq[$] != addrb)) addr_seq.push_back(addrb);
        end
    end

    bram_stream_reader #(
        .ADDR_W (4),
        .DATA_W (16),
        .RD_LAT (1)
    ) dut (
        .i_clk       (clk),
        .i_rst_n     (rst_n),
        .i_start     (start),
        .i_base_addr (base_addr),
        .i_len       (len),
        .o_busy      (busy),
        .o_done      (done),
        .o_addrb     (addrb),
        .i_doutb     (doutb),
        .o_m_valid   (m_valid),
        .i_m_ready   (m_ready),
        .o_m_data    (m_data)
    );

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    task automatic wait_done(input string tag, input int limit, output int ticks);
        ticks = 0;
        while (!done && ticks < limit) begin
            tick();
            ticks++;
        end
        check(tag, 32'(done), 32'd1);
    endtask

    task automatic check_stream(input string tag, input int cnt, input int first);
        check({tag, "_count"}, got.size(), cnt);
        for (int i = 0; i < cnt; i++) begin
            check($sformatf("%s_w%0d", tag, i), 32'(got[i]), 32'h0000_A000 + ((first + i) % 16));
        end
    endtask

    task automatic pulse_start(input logic [3:0] b, input logic [4:0] l);
        base_addr = b;
        len       = l;
        start     = 1'b1;
        tick();
        start     = 1'b0;
    endtask

    initial begin
        rst_n = 1'b0; start = 1'b0; base_addr = '0; len = '0; m_ready = 1'b0;
        wea = 1'b0; addra = '0; dina = '0;
        for (int i = 0; i < 16; i++) mem[i] = '0;
        #1;
        check("rst_busy", 32'(busy), 0);
        check("rst_done", 32'(done), 0);
        check("rst_m_valid", 32'(m_valid), 0);
        check("rst_m_data", 32'(m_data), 0);
        check("rst_addrb", 32'(addrb), 0);
        tick(); tick();
        rst_n = 1'b1;
        tick();

        // Preload through port A.
        for (int i = 0; i < 16; i++) begin
            wea = 1'b1; addra = 4'(i); dina = 16'hA000 + 16'(i);
            tick();
        end
        wea = 1'b0;

        // Full 16-word read, consumer always ready.
        m_ready = 1'b1;
        got.delete();
        pulse_start(4'd0, 5'd16);
        check("t1_busy_after_start", 32'(busy), 1);
        check("t1_valid_c1", 32'(m_valid), 0);
        tick();
        check("t1_valid_c2", 32'(m_valid), 0);
        tick();
        check("t1_valid_c3", 32'(m_valid), 1);
        check("t1_first_data", 32'(m_data), 32'h0000_A000);
        wait_done("t1_done_seen", 40, n);
        check("t1_cycles_to_done", n, 16);
        check("t1_busy_at_done", 32'(busy), 0);
        check_stream("t1", 16, 0);

        // Wrapping run, started in the done cycle of the previous transfer.
        got.delete();
        addr_seq.delete();
        pulse_start(4'd14, 5'd4);
        check("t2_done_falls", 32'(done), 0);
        check("t2_accepted_in_done_cycle", 32'(busy), 1);
        wait_done("t2_done_seen", 30, n);
        check_stream("t2", 4, 14);
        check("t2_addr0", 32'(addr_seq[0]), 14);
        check("t2_addr1", 32'(addr_seq[1]), 15);
        check("t2_addr2", 32'(addr_seq[2]), 0);
        check("t2_addr3", 32'(addr_seq[3]), 1);

        // Zero-length command.
        got.delete();
        pulse_start(4'd3, 5'd0);
        check("t3_done", 32'(done), 1);
        check("t3_busy", 32'(busy), 0);
        check("t3_valid", 32'(m_valid), 0);
        tick();
        check("t3_done_pulse", 32'(done), 0);
        check("t3_no_words", got.size(), 0);
        tick();

        // Backpressure: ready 1,0,1,0 then stalled for 10 cycles.
        got.delete();
        m_ready = 1'b1;
        pulse_start(4'd0, 5'd8);
        m_ready = 1'b0; tick();
        m_ready = 1'b1; tick();
        m_ready = 1'b0; tick();
        for (int i = 0; i < 10; i++) begin
            tick();
            check($sformatf("t4_stall_valid%0d", i), 32'(m_valid), 1);
            check($sformatf("t4_stall_data%0d", i), 32'(m_data), 32'h0000_A000 + got.size());
        end
        lead = addrb - 4'(got.size());
        check("t4_lead_le_depth", 32'(lead <= 4'd3), 1);
        m_ready = 1'b1;
        wait_done("t4_done_seen", 30, n);
        check_stream("t4", 8, 0);
        tick();

        // Start while busy is ignored.
        got.delete();
        done_cnt = 0;
        pulse_start(4'd2, 5'd6);
        tick();
        pulse_start(4'd9, 5'd3);
        wait_done("t5_done_seen", 30, n);
        check_stream("t5", 6, 2);
        for (int i = 0; i < 5; i++) tick();
        check("t5_single_done", done_cnt, 1);
        check("t5_no_extra_words", got.size(), 6);
        check("t5_idle", 32'(busy), 0);

        // Asynchronous reset mid-transfer, then a fresh short run.
        got.delete();
        pulse_start(4'd0, 5'd10);
        n = 0;
        while (got.size() < 3 && n < 20) begin
            tick();
            n++;
        end
        check("t6_three_accepted", got.size(), 3);
        rst_n = 1'b0;
        #1;
        check("t6_rst_busy", 32'(busy), 0);
        check("t6_rst_done", 32'(done), 0);
        check("t6_rst_valid", 32'(m_valid), 0);
        check("t6_rst_data", 32'(m_data), 0);
        check("t6_rst_addrb", 32'(addrb), 0);
        @(posedge clk);
        @(posedge clk);
        #1;
        rst_n = 1'b1;
        got.delete();
        tick();
        pulse_start(4'd5, 5'd2);
        wait_done("t6_done_seen", 20, n);
        check_stream("t6", 2, 5);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
